// File: rtl/nn_move_selector.sv
// nn_move_selector: picks the best-scoring empty cell from a network score flit
// and replays the cursor button sequence that places the mark there.
module nn_move_selector #(
    parameter int FLIT_DATA_WIDTH = 64,
    parameter int DEST_BITS       = 2,
    parameter int VC_BITS         = 1,
    parameter int PRESS_GAP       = 1
) (
    input  logic                                          Clk,
    input  logic                                          reset,
    input  logic [2+FLIT_DATA_WIDTH+DEST_BITS+VC_BITS-1:0] flit_in,
    input  logic [8:0]                                    P1,
    input  logic [8:0]                                    P2,
    output logic [VC_BITS:0]                              credit_out,
    output logic                                          send_credit,
    output logic                                          BtnU,
    output logic                                          BtnD,
    output logic                                          BtnL,
    output logic                                          BtnR,
    output logic                                          BtnC,
    output logic [3:0]                                    move_idx,
    output logic                                          move_valid,
    output logic                                          no_move,
    output logic                                          busy,
    output logic                                          overflow
);
    localparam int FW = 2 + FLIT_DATA_WIDTH + DEST_BITS + VC_BITS;
    localparam int PW = $clog2(PRESS_GAP + 2);
    localparam logic [2:0] B_U = 3'd1, B_D = 3'd2, B_L = 3'd3, B_R = 3'd4, B_C = 3'd5;

    typedef enum logic [1:0] {IDLE, SCAN, DRIVE, DONE} state_t;

    state_t                     state_q, state_d;
    logic [FLIT_DATA_WIDTH-2:0] scores_q, scores_d;
    logic [VC_BITS-1:0]         vc_q, vc_d;
    logic [8:0]                 occ_q, occ_d;
    logic [3:0]                 k_q, k_d, bidx_q, bidx_d, move_idx_q, move_idx_d;
    logic signed [6:0]          best_q, best_d, sc;
    logic                       found_q, found_d, cred_q, cred_d, overflow_q, overflow_d;
    logic [2:0]                 p_q, p_d, len, code;
    logic [PW-1:0]              ph_q, ph_d;
    logic [14:0]                seq;
    logic                       f_valid, f_flag, cand;
    logic [VC_BITS-1:0]         f_vc;
    logic                       unused_bits;

    assign f_valid     = flit_in[FW-1];
    assign f_vc        = flit_in[FLIT_DATA_WIDTH +: VC_BITS];
    assign f_flag      = flit_in[FLIT_DATA_WIDTH-1];
    assign unused_bits = ^flit_in[FW-2 -: 1+DEST_BITS];

    // Press lists, first press in the low bits; cursor returns to centre.
    always_comb begin
        case (move_idx_q)
            4'd0:    seq = {B_D, B_R, B_C, B_L, B_U};
            4'd1:    seq = {3'd0, 3'd0, B_D, B_C, B_U};
            4'd2:    seq = {B_D, B_L, B_C, B_R, B_U};
            4'd3:    seq = {3'd0, 3'd0, B_R, B_C, B_L};
            4'd5:    seq = {3'd0, 3'd0, B_L, B_C, B_R};
            4'd6:    seq = {B_U, B_R, B_C, B_L, B_D};
            4'd7:    seq = {3'd0, 3'd0, B_U, B_C, B_D};
            4'd8:    seq = {B_U, B_L, B_C, B_R, B_D};
            default: seq = {12'd0, B_C};
        endcase
        len  = (move_idx_q == 4'd4) ? 3'd1 : move_idx_q[0] ? 3'd3 : 3'd5;
        code = (state_q == DRIVE && ph_q == '0) ? seq[3*int'(p_q) +: 3] : 3'd0;
    end

    always_comb begin
        state_d    = state_q;
        scores_d   = scores_q;
        vc_d       = vc_q;
        occ_d      = occ_q;
        k_d        = k_q;
        bidx_d     = bidx_q;
        best_d     = best_q;
        found_d    = found_q;
        move_idx_d = move_idx_q;
        p_d        = p_q;
        ph_d       = ph_q;
        cred_d     = 1'b0;
        overflow_d = overflow_q | (f_valid && state_q != IDLE);
        sc         = scores_q[7*int'(k_q) +: 7];
        cand       = 1'b0;
        case (state_q)
            IDLE: if (f_valid) begin
                vc_d = f_vc;
                if (f_flag) begin
                    cred_d = 1'b1;
                end else begin
                    scores_d = flit_in[FLIT_DATA_WIDTH-2:0];
                    occ_d    = P1 | P2;
                    k_d      = 4'd0;
                    best_d   = -7'sd64;
                    found_d  = 1'b0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                cand = !occ_q[k_q] && sc >= best_q;
                if (cand) begin
                    best_d  = sc;
                    bidx_d  = k_q;
                    found_d = 1'b1;
                end
                k_d = k_q + 4'd1;
                if (k_q == 4'd8) begin
                    state_d    = (found_q || cand) ? DRIVE : DONE;
                    move_idx_d = cand ? k_q : bidx_q;
                    p_d        = 3'd0;
                    ph_d       = '0;
                end
            end
            DRIVE: if (ph_q == PW'(PRESS_GAP)) begin
                ph_d = '0;
                p_d  = p_q + 3'd1;
                if (p_q == len - 3'd1) state_d = DONE;
            end else begin
                ph_d = ph_q + PW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            scores_q   <= '0;
            vc_q       <= '0;
            occ_q      <= '0;
            k_q        <= '0;
            bidx_q     <= '0;
            best_q     <= '0;
            found_q    <= 1'b0;
            move_idx_q <= '0;
            p_q        <= '0;
            ph_q       <= '0;
            cred_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            scores_q   <= scores_d;
            vc_q       <= vc_d;
            occ_q      <= occ_d;
            k_q        <= k_d;
            bidx_q     <= bidx_d;
            best_q     <= best_d;
            found_q    <= found_d;
            move_idx_q <= move_idx_d;
            p_q        <= p_d;
            ph_q       <= ph_d;
            cred_q     <= cred_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy        = state_q != IDLE;
    assign send_credit = cred_q | (state_q == DONE);
    assign credit_out  = {send_credit, vc_q};
    assign move_valid  = state_q == DONE && found_q;
    assign no_move     = state_q == DONE && !found_q;
    assign move_idx    = move_idx_q;
    assign overflow    = overflow_q;
    assign BtnU        = code == B_U;
    assign BtnD        = code == B_D;
    assign BtnL        = code == B_L;
    assign BtnR        = code == B_R;
    assign BtnC        = code == B_C;
endmodule

// File: tb/tb_nn_move_selector.sv
// tb_nn_move_selector: directed checks of scan, tie-break, button timing and credits.
module tb_nn_move_selector;
    logic        Clk = 1'b0;
    logic        reset;
    logic [68:0] flit_in;
    logic [8:0]  P1, P2;
    logic [1:0]  credit_out;
    logic        send_credit, BtnU, BtnD, BtnL, BtnR, BtnC;
    logic [3:0]  move_idx;
    logic        move_valid, no_move, busy, overflow;
    int          checks = 0;
    int          failures = 0;

    localparam logic [4:0] U = 5'b10000, D = 5'b01000, L = 5'b00100, R = 5'b00010, C = 5'b00001, N = 5'b0;

    nn_move_selector dut (
        .Clk(Clk), .reset(reset), .flit_in(flit_in), .P1(P1), .P2(P2),
        .credit_out(credit_out), .send_credit(send_credit),
        .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR), .BtnC(BtnC),
        .move_idx(move_idx), .move_valid(move_valid), .no_move(no_move),
        .busy(busy), .overflow(overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [62:0] mk(input int base, input int ca, input int va, input int cb, input int vb);
        logic [62:0] s;
        for (int k = 0; k < 9; k++) s[7*k +: 7] = 7'(k == ca ? va : k == cb ? vb : base);
        return s;
    endfunction

    function automatic logic [15:0] all_out();
        return {credit_out, send_credit, BtnU, BtnD, BtnL, BtnR, BtnC, move_idx, move_valid, no_move, busy, overflow};
    endfunction

    task automatic send(input logic flag, input logic vc, input logic [62:0] s);
        flit_in = {1'b1, 1'b1, 2'b00, vc, flag, s};
        @(posedge Clk);
        @(negedge Clk);
        flit_in = '0;
    endtask

    task automatic observe(input logic is_move, input logic [3:0] eidx, input logic vc, input int len,
                           input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] s3, input logic [4:0] s4, input int inj);
        logic [4:0] seq [5];
        logic [4:0] eb;
        int d;
        seq = '{s0, s1, s2, s3, s4};
        d = is_move ? 10 + 2*len : 10;
        for (int i = 1; i <= d + 3; i++) begin
            eb = N;
            if (is_move && i >= 10 && i < d && (i - 10) % 2 == 0) eb = seq[(i-10)/2];
            chk($sformatf("btn@%0d", i), {BtnU, BtnD, BtnL, BtnR, BtnC}, eb);
            chk($sformatf("busy@%0d", i), busy, i <= d);
            chk($sformatf("move_valid@%0d", i), move_valid, is_move && i == d);
            chk($sformatf("no_move@%0d", i), no_move, !is_move && i == d);
            chk($sformatf("send_credit@%0d", i), send_credit, i == d);
            if (i == d) begin
                chk("credit_out", credit_out, {1'b1, vc});
                if (is_move) chk("move_idx", move_idx, eidx);
            end
            flit_in = (i == inj) ? {1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 63'h0} : '0;
            @(negedge Clk);
        end
    endtask

    initial begin
        reset = 1'b1; flit_in = '0; P1 = '0; P2 = '0;
        repeat (2) @(negedge Clk);
        chk("reset_outputs", all_out(), 16'h0);
        reset = 1'b0;
        @(negedge Clk);

        send(1'b0, 1'b1, mk(-10, 5, 40, 5, 40));
        observe(1'b1, 4'd5, 1'b1, 3, R, C, L, N, N, 0);

        P2 = 9'h020;
        send(1'b0, 1'b0, mk(-10, 5, 40, 2, 30));
        P2 = '0;
        observe(1'b1, 4'd2, 1'b0, 5, U, R, C, L, D, 0);

        send(1'b0, 1'b1, mk(3, 0, 3, 0, 3));
        observe(1'b1, 4'd8, 1'b1, 5, D, R, C, L, U, 0);

        P1 = 9'h0F0; P2 = 9'h10F;
        send(1'b0, 1'b1, mk(5, 0, 5, 0, 5));
        observe(1'b0, 4'd0, 1'b1, 0, N, N, N, N, N, 0);
        chk("overflow_clear", overflow, 1'b0);
        P1 = '0; P2 = '0;

        send(1'b1, 1'b1, mk(0, 0, 0, 0, 0));
        chk("bp_credit", {send_credit, credit_out}, 3'b111);
        chk("bp_idle", {busy, BtnU, BtnD, BtnL, BtnR, BtnC}, 6'h0);
        @(negedge Clk);
        chk("bp_credit_once", send_credit, 1'b0);
        send(1'b0, 1'b0, mk(-64, 4, 63, 4, 63));
        observe(1'b1, 4'd4, 1'b0, 1, C, N, N, N, N, 10);
        chk("overflow_set", overflow, 1'b1);

        send(1'b0, 1'b1, mk(-64, 0, 63, 0, 63));
        repeat (11) @(negedge Clk);
        chk("pre_reset_press", {BtnU, BtnD, BtnL, BtnR, BtnC, busy}, {L, 1'b1});
        #1 reset = 1'b1;
        #1 chk("mid_reset", all_out(), 16'h0);
        @(negedge Clk);
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge Clk);
            chk($sformatf("post_reset_quiet@%0d", i), {move_valid, send_credit, busy}, 3'b000);
        end

        send(1'b0, 1'b0, mk(-10, 5, 40, 5, 40));
        observe(1'b1, 4'd5, 1'b0, 3, R, C, L, N, N, 0);
        chk("overflow_after_reset", overflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nn_move_selector.md
Name: nn_move_selector

Overview:
- Consumes the network output flit that carries the neural network's 63-bit hypothesis: nine signed 7-bit scores, one per board cell.
- Picks the highest-scoring empty cell from the current board occupancy.
- Drives the tic_tac_toe button inputs with the cursor sequence that places the mark in that cell.
- Returns a credit to the network's receive port when the flit slot frees.

Parameters:
- FLIT_DATA_WIDTH, 64, flit payload width: bit 63 = backprop flag, bits 62:0 = scores.
- DEST_BITS, 2, destination field width.
- VC_BITS, 1, VC field width.
- PRESS_GAP, 1, low cycles after each one-cycle button pulse.

Ports:
- Clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flit_in  in  2+FLIT_DATA_WIDTH+DEST_BITS+VC_BITS  recv-port flit, laid out as {valid, tail, dest, vc, flag, scores[62:0]}; valid is the MSB.
- P1  in  9  player-1 occupancy.
- P2  in  9  player-2 occupancy.
- credit_out  out  1+VC_BITS  credit, laid out as {valid, vc}.
- send_credit  out  1  credit enable.
- BtnU, BtnD, BtnL, BtnR, BtnC  out  1 each  button pulses to the board.
- move_idx  out  4  selected cell, 0..8.
- move_valid  out  1  one-cycle pulse when the button sequence completes.
- no_move  out  1  one-cycle pulse when the board is full.
- busy  out  1  high whenever the FSM is not in IDLE.
- overflow  out  1  sticky; set when a flit is dropped; cleared only by reset.

Behaviour:
- Reset (asynchronous, any state): all outputs 0, move_idx=0, FSM=IDLE, internal registers cleared. A sequence in progress is abandoned mid-press with the buttons released.
- Score k = scores[7k+6:7k], two's complement, range -64..63.
- IDLE, valid=1, flag=0:
  - Register scores, vc and occ=P1|P2 at this edge (cycle 0). Later board changes are ignored.
  - Go to SCAN.
- IDLE, valid=1, flag=1 (backprop flit):
  - Discard it.
  - Next cycle: send_credit=1, credit_out={1,vc}.
  - Stay in IDLE.
- SCAN:
  - Runs 9 cycles (1..9), examining cell k=0..8 one per cycle.
  - Occupied cells are skipped.
  - Candidate replaces best when score >= best, so ties resolve to the higher index.
  - best initialises to -64 with found=0.
- After SCAN:
  - found=1: go to DRIVE with move_idx=best index.
  - found=0: pulse no_move, return the credit, go to IDLE.
- DRIVE:
  - Cursor starts and ends at centre.
  - Per-cell sequences:
    - 0: U,L,C,R,D
    - 1: U,C,D
    - 2: U,R,C,L,D
    - 3: L,C,R
    - 4: C
    - 5: R,C,L
    - 6: D,L,C,R,U
    - 7: D,C,U
    - 8: D,R,C,L,U
  - Each press: one cycle high, then PRESS_GAP cycles with all buttons low.
  - At most one button is high in any cycle.
  - A sequence of N presses takes N*(1+PRESS_GAP) cycles.
- DONE:
  - One cycle: move_valid=1, send_credit=1, credit_out={1,vc}.
  - Then IDLE.
- Latency with PRESS_GAP=1:
  - First press in cycle 10.
  - Cell 4: move_valid in cycle 12.
  - Cell 0: move_valid in cycle 20.
- A valid flit arriving while busy=1 is dropped, sets overflow, and earns no credit.
- A flit arriving in the same cycle as the DONE credit is also dropped.
- send_credit is never high for more than one cycle per flit.
- The block uses one buffer slot; the network is configured with 1 credit on this port.
- Board full means occ=9'h1FF.
- Invalid flits (valid=0) are ignored in every state.

Test Plan:
- Empty board; scores with cell 5=+40, all others -10 -> move_idx=5; presses R,C,L on cycles 10,12,14; move_valid cycle 16; one credit with the correct vc.
- Cell 5 occupied in P2; cell 5=+40, cell 2=+30 -> move_idx=2; sequence U,R,C,L,D.
- All scores equal (+3), board empty -> move_idx=8 (tie goes high); ends with U.
- P1|P2=9'h1FF -> no_move pulse after 9 scan cycles, no button activity, one credit.
- Backprop flit (flag=1) -> no buttons, credit next cycle. Then a second forward flit during DRIVE -> overflow=1 and dropped, first move still completes.
- Assert reset during DRIVE -> same edge: all buttons 0, busy=0, move_valid never pulses. A new flit after reset is processed normally.
